// File: rtl/cu_data_read_command_generator.sv
// -----------------------------------------------------------------------------
// cu_data_read_command_generator
//
// Compute-unit stage that feeds the AFU-Control read command buffer. It takes
// one read job at a time (byte base address + element count, 4-byte elements)
// and cuts it into cacheline-sized read commands tagged with the data-read CU
// ID. Outstanding commands are bounded by a local credit budget; every read
// response hands one credit back. Once the last response is home, done pulses
// for one cycle.
//
// Ports
//   clock, reset          : sole clock, synchronous active-high reset
//   enabled               : gates job acceptance and command issue
//   job_valid/job_ready   : job handshake
//   job_base_addr         : byte address of element 0 (must be element aligned)
//   job_num_elements      : element count (0 completes without commands)
//   cmd_valid/cmd_ready   : command handshake towards the command buffer
//   cmd_address           : cacheline-aligned byte address of the command
//   cmd_size, cmd_cu_id   : constant CACHELINE_SIZE and CU_ID
//   rsp_valid             : one read response returned (one credit back)
//   busy                  : a job is in progress
//   done                  : one-cycle completion pulse
//   error                 : sticky (misaligned base or credit overflow)
// -----------------------------------------------------------------------------
module cu_data_read_command_generator #(
   parameter logic [7:0] CU_ID          = 8'hFB,
   parameter int         CACHELINE_SIZE = 128,
   parameter int         ARRAY_SIZE     = 4,
   parameter int         CREDITS        = 32
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enabled,
   input  logic        job_valid,
   output logic        job_ready,
   input  logic [63:0] job_base_addr,
   input  logic [31:0] job_num_elements,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic [63:0] cmd_address,
   output logic [7:0]  cmd_size,
   output logic [7:0]  cmd_cu_id,
   input  logic        rsp_valid,
   output logic        busy,
   output logic        done,
   output logic        error
);

   localparam int LINE_SHIFT = $clog2(CACHELINE_SIZE);
   localparam int ELEM_SHIFT = $clog2(ARRAY_SIZE);
   localparam int CW         = $clog2(CREDITS + 1);

   localparam logic [CW-1:0] CREDITS_FULL = CW'(CREDITS);
   localparam logic [63:0]   LINE_MASK    = 64'(CACHELINE_SIZE - 1);
   localparam logic [63:0]   LINE_BYTES   = 64'(CACHELINE_SIZE);
   localparam logic [63:0]   ELEM_MASK    = 64'(ARRAY_SIZE - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CALC  = 3'd1;
   localparam logic [2:0] S_ISSUE = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]    state;
   logic [63:0]   base_q;
   logic [31:0]   count_q;
   logic [63:0]   addr_q;
   logic [63:0]   remaining;
   logic [CW-1:0] credits;
   logic          issue;
   logic          credit_overflow;
   logic [63:0]   job_bytes;
   logic [63:0]   last_byte;
   logic [63:0]   line_count;

   // Saturating credit update: a response and an issue in the same cycle cancel.
   function automatic logic [CW-1:0] credit_next(input logic [CW-1:0] cur,
                                                 input logic          inc,
                                                 input logic          dec);
      logic [CW-1:0] nxt;
      nxt = cur;
      if (inc && !dec) begin
         if (cur != CREDITS_FULL) nxt = cur + CW'(1);
      end else if (dec && !inc) begin
         nxt = cur - CW'(1);
      end
      return nxt;
   endfunction

   // Reset is folded into the handshakes so nothing is accepted or issued
   // in a cycle whose state is about to be discarded.
   assign job_ready   = (state == S_IDLE) && enabled && !reset;
   assign cmd_valid   = (state == S_ISSUE) && enabled && !reset &&
                        (credits != '0) && (remaining != '0);
   assign issue       = cmd_valid && cmd_ready;
   assign cmd_address = addr_q;
   assign cmd_size    = 8'(CACHELINE_SIZE);
   assign cmd_cu_id   = CU_ID;
   assign busy        = (state != S_IDLE);
   assign done        = (state == S_DONE);

   // Number of cachelines touched by [base, base + bytes); modulo 2^64.
   assign job_bytes  = {32'd0, count_q} << ELEM_SHIFT;
   assign last_byte  = base_q + job_bytes - 64'd1;
   assign line_count = (last_byte >> LINE_SHIFT) - (base_q >> LINE_SHIFT) + 64'd1;

   // A response with no credit outstanding is an overflow unless an issue
   // in the same cycle consumes the returned credit.
   assign credit_overflow = rsp_valid && !issue && (credits == CREDITS_FULL);

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= S_IDLE;
         credits   <= CREDITS_FULL;
         error     <= 1'b0;
         addr_q    <= '0;
         remaining <= '0;
      end else begin
         credits <= credit_next(credits, rsp_valid, issue);
         if (credit_overflow) error <= 1'b1;

         case (state)
            S_IDLE: begin
               if (job_valid && job_ready) begin
                  if ((job_base_addr & ELEM_MASK) != 64'd0) begin
                     error <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     state <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               addr_q <= base_q & ~LINE_MASK;
               if (count_q == 32'd0) begin
                  remaining <= '0;
                  state     <= S_DONE;
               end else begin
                  remaining <= line_count;
                  state     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (issue) begin
                  addr_q    <= addr_q + LINE_BYTES;
                  remaining <= remaining - 64'd1;
                  if (remaining == 64'd1) state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (credits == CREDITS_FULL) state <= S_DONE;
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Job parameters are plain data: captured on accept, never reset.
   always_ff @(posedge clock) begin
      if (job_valid && job_ready) begin
         base_q  <= job_base_addr;
         count_q <= job_num_elements;
      end
   end

endmodule

// File: tb/tb_cu_data_read_command_generator.sv
// -----------------------------------------------------------------------------
// Testbench for cu_data_read_command_generator.
// A cycle-level reference model predicts every output from the job rules:
// the expected command stream is the list of cachelines covering the job's
// byte range, and completion follows the last returned response. Directed
// jobs pin the model with hand-computed literals; random jobs follow.
// -----------------------------------------------------------------------------
module tb_cu_data_read_command_generator;

   localparam int CREDITS = 32;

   logic        clk = 1'b0;
   logic        reset;
   logic        enabled;
   logic        job_valid;
   logic        job_ready;
   logic [63:0] job_base_addr;
   logic [31:0] job_num_elements;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [63:0] cmd_address;
   logic [7:0]  cmd_size;
   logic [7:0]  cmd_cu_id;
   logic        rsp_valid;
   logic        busy;
   logic        done;
   logic        error;

   cu_data_read_command_generator dut (
      .clock            (clk),
      .reset            (reset),
      .enabled          (enabled),
      .job_valid        (job_valid),
      .job_ready        (job_ready),
      .job_base_addr    (job_base_addr),
      .job_num_elements (job_num_elements),
      .cmd_valid        (cmd_valid),
      .cmd_ready        (cmd_ready),
      .cmd_address      (cmd_address),
      .cmd_size         (cmd_size),
      .cmd_cu_id        (cmd_cu_id),
      .rsp_valid        (rsp_valid),
      .busy             (busy),
      .done             (done),
      .error            (error)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   int ncyc        = 0;

   // Observations recorded by the monitor
   int          fires    = 0;
   logic [63:0] fire_addr[$];
   int          done_cnt = 0;
   int          done_cyc = 0;
   int          acc_cyc  = 0;

   // Response generation controls (written by stimulus only)
   bit hold_rsp  = 1'b0;
   bit rnd_rsp   = 1'b0;
   bit rnd_mode  = 1'b0;
   int rsp_delay = 3;
   int rel_req   = 0;
   int rel_done  = 0;
   int due_q[$];

   // Reference model state
   bit          armed  = 1'b0;
   bit          m_busy = 1'b0;
   bit          m_done = 1'b0;
   bit          m_err  = 1'b0;
   int          m_wait = 0;
   int          m_out  = 0;
   logic [63:0] m_q[$];
   logic        e_valid;
   logic        fire_m;
   logic        q_was_empty;
   int          out_was;
   logic [63:0] a_it, a_hi, junk64;
   int          junk_int;
   bit          rsp_nxt;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, ncyc);
      end
   endtask

   // Monitor + model: at each negedge check this cycle's outputs, choose the
   // response for the coming edge, then advance the model across that edge.
   initial begin : monitor
      rsp_valid = 1'b0;
      forever begin
         @(negedge clk);
         ncyc++;
         e_valid = m_busy && !m_done && (m_wait == 0) && (m_q.size() > 0) &&
                   enabled && !reset && (m_out < CREDITS);
         if (armed) begin
            chk("job_ready", 64'(job_ready), 64'(!m_busy && enabled && !reset));
            chk("busy",      64'(busy),      64'(m_busy));
            chk("done",      64'(done),      64'(m_done));
            chk("error",     64'(error),     64'(m_err));
            chk("cmd_valid", 64'(cmd_valid), 64'(e_valid));
            chk("cmd_size",  64'(cmd_size),  64'h80);
            chk("cmd_cu_id", 64'(cmd_cu_id), 64'hFB);
            if (e_valid) chk("cmd_address", cmd_address, m_q[0]);
         end

         if (done) begin done_cnt++; done_cyc = ncyc; end
         if (job_valid && job_ready) acc_cyc = ncyc;

         rsp_nxt = 1'b0;
         if (reset) begin
            due_q.delete();
         end else if (due_q.size() > 0) begin
            if (rel_done < rel_req) begin
               rsp_nxt = 1'b1;
               rel_done++;
            end else if (!hold_rsp && due_q[0] <= ncyc) begin
               rsp_nxt = 1'b1;
            end
            if (rsp_nxt) junk_int = due_q.pop_front();
         end
         rsp_valid = rsp_nxt;

         if (cmd_valid && cmd_ready && !reset) begin
            fires++;
            fire_addr.push_back(cmd_address);
            due_q.push_back(ncyc + (rnd_rsp ? int'($urandom_range(1, 10)) : rsp_delay));
         end

         if (reset) begin
            armed  = 1'b1;
            m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
            m_wait = 0;    m_out  = 0;    m_q.delete();
         end else begin
            fire_m      = e_valid && cmd_ready;
            q_was_empty = (m_q.size() == 0);
            out_was     = m_out;
            if (rsp_valid) begin
               if (m_out == 0 && !fire_m) m_err = 1'b1;
               else m_out--;
            end
            if (fire_m) begin
               junk64 = m_q.pop_front();
               m_out++;
            end
            if (m_done) begin
               m_done = 1'b0;
               m_busy = 1'b0;
            end else if (m_busy) begin
               if (m_wait > 0) m_wait--;
               else if (q_was_empty && out_was == 0) m_done = 1'b1;
            end else if (enabled && job_valid) begin
               m_busy = 1'b1;
               if (job_base_addr[1:0] != 2'b00) begin
                  m_err  = 1'b1;
                  m_done = 1'b1;
               end else if (job_num_elements == 32'd0) begin
                  m_wait = 0;
               end else begin
                  m_wait = 1;
                  a_hi = job_base_addr + (64'(job_num_elements) << 2);
                  a_it = job_base_addr & ~64'd127;
                  while (a_it < a_hi) begin
                     m_q.push_back(a_it);
                     a_it = a_it + 64'd128;
                  end
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      if (rnd_mode) begin
         cmd_ready = ($urandom_range(0, 3) != 0);
         enabled   = ($urandom_range(0, 9) != 0);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic submit(input logic [63:0] b, input logic [31:0] n);
      bit ok;
      ok = 1'b0;
      job_base_addr    = b;
      job_num_elements = n;
      job_valid        = 1'b1;
      for (int k = 0; k < 200 && !ok; k++) begin
         @(negedge clk);
         if (job_ready) ok = 1'b1;
         step();
      end
      job_valid = 1'b0;
      chk("job_accepted", 64'(ok), 64'd1);
   endtask

   task automatic wait_done(input int limit);
      int d0;
      int k;
      d0 = done_cnt;
      k  = 0;
      while (done_cnt == d0 && k < limit) begin
         step();
         k++;
      end
      chk("done_seen", 64'(done_cnt != d0), 64'd1);
   endtask

   initial begin : stimulus
      int f0, d0;
      logic [63:0] b;
      logic [31:0] n;

      reset = 1'b1; enabled = 1'b1; job_valid = 1'b0; cmd_ready = 1'b1;
      job_base_addr = '0; job_num_elements = '0;
      step(); step(); step();
      chk("rst_cmd_address", cmd_address, 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      reset = 1'b0;
      step();

      // 1: single line job
      f0 = fires; d0 = done_cnt; rsp_delay = 3;
      submit(64'h1000, 32'd32);
      wait_done(100);
      repeat (5) step();
      chk("t1_cmds", 64'(fires - f0), 64'd1);
      chk("t1_addr", fire_addr[f0], 64'h1000);
      chk("t1_dones", 64'(done_cnt - d0), 64'd1);

      // 2: job straddling a line boundary
      f0 = fires;
      submit(64'h1040, 32'd32);
      wait_done(100);
      chk("t2_cmds", 64'(fires - f0), 64'd2);
      chk("t2_addr0", fire_addr[f0], 64'h1000);
      chk("t2_addr1", fire_addr[f0 + 1], 64'h1080);

      // 3: credit exhaustion and partial return
      f0 = fires; d0 = done_cnt; hold_rsp = 1'b1;
      submit(64'h0, 32'd2048);
      repeat (60) step();
      chk("t3_burst", 64'(fires - f0), 64'd32);
      chk("t3_last_addr", fire_addr[fires - 1], 64'hF80);
      chk("t3_stalled", 64'(cmd_valid), 64'd0);
      rel_req = rel_req + 5;
      repeat (30) step();
      chk("t3_after_5", 64'(fires - f0), 64'd37);
      hold_rsp = 1'b0;
      wait_done(1000);
      repeat (5) step();
      chk("t3_total", 64'(fires - f0), 64'd64);
      chk("t3_dones", 64'(done_cnt - d0), 64'd1);

      // 4: empty job, misaligned base
      f0 = fires;
      submit(64'h2000, 32'd0);
      wait_done(20);
      chk("t4_zero_latency", 64'(done_cyc - acc_cyc), 64'd2);
      chk("t4_zero_cmds", 64'(fires - f0), 64'd0);
      submit(64'h1002, 32'd8);
      wait_done(20);
      chk("t4_misaligned_err", 64'(error), 64'd1);
      chk("t4_misaligned_cmds", 64'(fires - f0), 64'd0);

      // 5: backpressure holds the command stable
      do_reset();
      f0 = fires; cmd_ready = 1'b0;
      submit(64'h2000, 32'd256);
      repeat (3) step();
      chk("t5_valid_start", 64'(cmd_valid), 64'd1);
      chk("t5_addr_start", cmd_address, 64'h2000);
      repeat (10) step();
      chk("t5_valid_held", 64'(cmd_valid), 64'd1);
      chk("t5_addr_held", cmd_address, 64'h2000);
      chk("t5_no_cmds", 64'(fires - f0), 64'd0);
      cmd_ready = 1'b1;
      wait_done(200);
      chk("t5_cmds", 64'(fires - f0), 64'd8);

      // 6: reset in the middle of issue
      f0 = fires; d0 = done_cnt; hold_rsp = 1'b1;
      submit(64'h0, 32'd2048);
      for (int k = 0; k < 200 && (fires - f0) < 10; k++) step();
      reset = 1'b1;
      step();
      chk("t6_cmds", 64'(fires - f0), 64'd10);
      chk("t6_valid", 64'(cmd_valid), 64'd0);
      chk("t6_busy", 64'(busy), 64'd0);
      chk("t6_done", 64'(done), 64'd0);
      chk("t6_error", 64'(error), 64'd0);
      chk("t6_job_ready", 64'(job_ready), 64'd0);
      chk("t6_addr", cmd_address, 64'd0);
      chk("t6_size", 64'(cmd_size), 64'd128);
      chk("t6_cu_id", 64'(cmd_cu_id), 64'hFB);
      step();
      reset = 1'b0;
      step();
      chk("t6_no_done", 64'(done_cnt - d0), 64'd0);
      f0 = fires;
      submit(64'h0, 32'd2048);
      repeat (60) step();
      chk("t6_full_credits", 64'(fires - f0), 64'd32);
      hold_rsp = 1'b0;
      wait_done(1000);
      chk("t6_total", 64'(fires - f0), 64'd64);

      // Random jobs under random backpressure, enable and response delay
      do_reset();
      rnd_rsp = 1'b1; rnd_mode = 1'b1;
      for (int j = 0; j < 25; j++) begin
         b = {24'd0, 8'($urandom_range(0, 255)), 32'($urandom)};
         if ($urandom_range(0, 7) != 0) b[1:0] = 2'b00;
         n = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 700));
         submit(b, n);
         if ($urandom_range(0, 7) == 0) begin
            repeat ($urandom_range(2, 20)) step();
            do_reset();
         end else begin
            wait_done(3000);
         end
         repeat ($urandom_range(0, 3)) step();
      end
      rnd_mode = 1'b0; enabled = 1'b1; cmd_ready = 1'b1;
      repeat (5) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1);
   end

endmodule
